// File: rtl/fdiv_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The slave side is the divider; the master side is its controller.
interface fdiv_prog_if #(
  parameter int unsigned W = 8
);
  logic         en;
  logic         clr;
  logic         cfg_ld;
  logic [W-1:0] cfg_div;
  logic         cfg_mode;
  logic         cfg_pend;
  logic         fdclk;
  logic         tick;
  logic [W-1:0] cnt;
  logic [W-1:0] div_cur;

  modport master (
    output en, clr, cfg_ld, cfg_div, cfg_mode,
    input  cfg_pend, fdclk, tick, cnt, div_cur
  );

  modport slave (
    input  en, clr, cfg_ld, cfg_div, cfg_mode,
    output cfg_pend, fdclk, tick, cnt, div_cur
  );
endinterface

// File: rtl/fdiv_prog.sv
// Runtime-programmable clock divider with pulse/square output.
// A new ratio/mode is shadowed and applied only at a period boundary.
module fdiv_prog #(
  parameter int unsigned W            = 8,
  parameter int unsigned DEFAULT_DIV  = 5,
  parameter bit          DEFAULT_MODE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  fdiv_prog_if.slave   bus
);

  localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic         mode_q, mode_d;
  logic [W-1:0] sh_div_q, sh_div_d;
  logic         sh_mode_q, sh_mode_d;
  logic         pend_q, pend_d;
  logic         fdclk_q, fdclk_d;
  logic         tick_q, tick_d;

  logic         stopped;
  logic         wrap;
  logic         boundary;
  logic [W:0]   half;

  // A stopped divider treats every cycle as a boundary so config can land.
  always_comb begin
    stopped  = (div_q == '0);
    wrap     = bus.en && !bus.clr && !stopped && (cnt_q == (div_q - W'(1)));
    boundary = bus.clr || stopped || wrap;

    cnt_d     = cnt_q;
    div_d     = div_q;
    mode_d    = mode_q;
    sh_div_d  = sh_div_q;
    sh_mode_d = sh_mode_q;
    pend_d    = pend_q;

    if (boundary) begin
      cnt_d  = '0;
      pend_d = 1'b0;
      if (bus.cfg_ld) begin
        div_d  = bus.cfg_div;
        mode_d = bus.cfg_mode;
      end else if (pend_q) begin
        div_d  = sh_div_q;
        mode_d = sh_mode_q;
      end
    end else begin
      if (bus.en) begin
        cnt_d = cnt_q + W'(1);
      end
      if (bus.cfg_ld) begin
        sh_div_d  = bus.cfg_div;
        sh_mode_d = bus.cfg_mode;
        pend_d    = 1'b1;
      end
    end

    tick_d = wrap && (div_d != '0);

    // Half-period threshold is computed one bit wider so 2^W-1 cannot overflow.
    half = ({1'b0, div_d} + (W+1)'(1)) >> 1;
    if (div_d == '0) begin
      fdclk_d = 1'b0;
    end else if (mode_d) begin
      fdclk_d = ({1'b0, cnt_d} < half);
    end else begin
      fdclk_d = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      div_q     <= DEF_DIV;
      mode_q    <= DEFAULT_MODE;
      sh_div_q  <= '0;
      sh_mode_q <= 1'b0;
      pend_q    <= 1'b0;
      fdclk_q   <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      mode_q    <= mode_d;
      sh_div_q  <= sh_div_d;
      sh_mode_q <= sh_mode_d;
      pend_q    <= pend_d;
      fdclk_q   <= fdclk_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.cnt      = cnt_q;
  assign bus.div_cur  = div_q;
  assign bus.cfg_pend = pend_q;
  assign bus.fdclk    = fdclk_q;
  assign bus.tick     = tick_q;

endmodule

// File: tb/tb_fdiv_prog.sv
// Directed, table-driven check of fdiv_prog (W=8, default N=5 pulse).
// Each row drives one cycle of inputs and lists the outputs expected after that edge.
module tb_fdiv_prog;

  typedef struct packed {
    logic       en;
    logic       clr;
    logic       ld;
    logic [7:0] div;
    logic       mode;
    logic [7:0] ecnt;
    logic       efd;
    logic       etick;
    logic       epend;
    logic [7:0] ediv;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];

  fdiv_prog_if #(.W(8)) bus ();

  fdiv_prog #(.W(8), .DEFAULT_DIV(5), .DEFAULT_MODE(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input logic en, input logic clr, input logic ld, input int div,
                     input logic mode, input int ecnt, input logic efd, input logic etick,
                     input logic epend, input int ediv);
    vec_t v;
    v.en = en; v.clr = clr; v.ld = ld; v.div = 8'(div); v.mode = mode;
    v.ecnt = 8'(ecnt); v.efd = efd; v.etick = etick; v.epend = epend; v.ediv = 8'(ediv);
    tbl.push_back(v);
  endtask

  task automatic drive(input logic en, input logic clr, input logic ld, input logic [7:0] div,
                       input logic mode);
    bus.en = en; bus.clr = clr; bus.cfg_ld = ld; bus.cfg_div = div; bus.cfg_mode = mode;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Packs {cnt, fdclk, tick, cfg_pend, div_cur} for one-shot state comparison.
  function automatic logic [31:0] pack(input logic [7:0] c, input logic f, input logic t,
                                       input logic p, input logic [7:0] d);
    return {13'd0, c, f, t, p, d};
  endfunction

  function automatic logic [31:0] dut_state();
    return pack(bus.cnt, bus.fdclk, bus.tick, bus.cfg_pend, bus.div_cur);
  endfunction

  initial begin
    int hi;
    int lo;
    drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // en clr ld div mode | cnt fd tick pend div
    for (int i = 1; i <= 4; i++) add(1,0,0,0,0, i,0,0,0,5);
    add(1,0,0,0,0, 0,1,1,0,5);
    add(1,0,0,0,0, 1,0,0,0,5);
    add(1,0,0,0,0, 2,0,0,0,5);
    // switch to square at cnt=2
    add(1,0,1,5,1, 3,0,0,1,5);
    add(1,0,0,0,0, 4,0,0,1,5);
    add(1,0,0,0,0, 0,1,1,0,5);
    add(1,0,0,0,0, 1,1,0,0,5);
    add(1,0,0,0,0, 2,1,0,0,5);
    add(1,0,0,0,0, 3,0,0,0,5);
    add(1,0,0,0,0, 4,0,0,0,5);
    add(1,0,0,0,0, 0,1,1,0,5);
    // last write wins: 3 then 7
    add(1,0,1,3,0, 1,1,0,1,5);
    add(1,0,1,7,0, 2,1,0,1,5);
    add(1,0,0,0,0, 3,0,0,1,5);
    add(1,0,0,0,0, 4,0,0,1,5);
    add(1,0,0,0,0, 0,1,1,0,7);
    for (int i = 1; i <= 6; i++) add(1,0,0,0,0, i,0,0,0,7);
    // load coincident with wrap bypasses the shadow
    add(1,0,1,2,0, 0,1,1,0,2);
    add(1,0,0,0,0, 1,0,0,0,2);
    add(1,0,0,0,0, 0,1,1,0,2);
    add(1,0,0,0,0, 1,0,0,0,2);
    add(1,0,1,5,0, 0,1,1,0,5);
    add(1,0,0,0,0, 1,0,0,0,5);
    add(1,0,0,0,0, 2,0,0,0,5);
    add(1,0,0,0,0, 3,0,0,0,5);
    // clr at cnt=3, then en=0 hold
    add(1,1,0,0,0, 0,1,0,0,5);
    add(1,0,0,0,0, 1,0,0,0,5);
    add(1,0,0,0,0, 2,0,0,0,5);
    for (int i = 0; i < 4; i++) add(0,0,0,0,0, 2,0,0,0,5);
    add(1,0,0,0,0, 3,0,0,0,5);
    // N=1
    add(1,0,1,1,0, 4,0,0,1,5);
    add(1,0,0,0,0, 0,1,1,0,1);
    add(1,0,0,0,0, 0,1,1,0,1);
    add(1,0,0,0,0, 0,1,1,0,1);
    // N=0, then load N=4 with en=0
    add(1,0,1,0,0, 0,0,0,0,0);
    add(1,0,0,0,0, 0,0,0,0,0);
    add(0,0,1,4,0, 0,1,0,0,4);
    add(0,0,0,0,0, 0,1,0,0,4);
    add(1,0,0,0,0, 1,0,0,0,4);
    add(1,0,0,0,0, 2,0,0,0,4);
    // pending config held while disabled
    add(0,0,1,5,0, 2,0,0,1,4);
    add(0,0,0,0,0, 2,0,0,1,4);
    add(1,0,0,0,0, 3,0,0,1,4);
    add(1,0,0,0,0, 0,1,1,0,5);
    // clr applies a pending config
    add(1,0,1,3,1, 1,0,0,1,5);
    add(1,1,0,0,0, 0,1,0,0,3);
    add(1,0,0,0,0, 1,1,0,0,3);
    add(1,0,0,0,0, 2,0,0,0,3);
    add(1,0,0,0,0, 0,1,1,0,3);

    step();
    step();
    chk("reset_state", dut_state(), pack(8'd0, 1'b1, 1'b0, 1'b0, 8'd5));
    rst = 1'b0;
    step();
    chk("idle_after_reset", dut_state(), pack(8'd0, 1'b1, 1'b0, 1'b0, 8'd5));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].ld, tbl[i].div, tbl[i].mode);
      step();
      chk($sformatf("row%0d", i), dut_state(),
          pack(tbl[i].ecnt, tbl[i].efd, tbl[i].etick, tbl[i].epend, tbl[i].ediv));
    end

    // Max ratio in square mode: 128 high, 127 low per period.
    drive(1'b1, 1'b1, 1'b1, 8'd255, 1'b1);
    step();
    chk("n255_load", dut_state(), pack(8'd0, 1'b1, 1'b0, 1'b0, 8'd255));
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    hi = 1;
    lo = 0;
    for (int i = 1; i <= 254; i++) begin
      step();
      if (bus.tick) chk($sformatf("n255_early_tick%0d", i), 32'(bus.tick), 32'd0);
      if (bus.fdclk) hi++; else lo++;
    end
    chk("n255_high", 32'(hi), 32'd128);
    chk("n255_low", 32'(lo), 32'd127);
    chk("n255_last_cnt", 32'(bus.cnt), 32'd254);
    step();
    chk("n255_wrap", dut_state(), pack(8'd0, 1'b1, 1'b1, 1'b0, 8'd255));

    // Async reset mid-period with a config pending.
    drive(1'b1, 1'b1, 1'b1, 8'd5, 1'b0);
    step();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    step();
    step();
    drive(1'b1, 1'b0, 1'b1, 8'd7, 1'b1);
    step();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    chk("pre_reset", dut_state(), pack(8'd3, 1'b0, 1'b0, 1'b1, 8'd5));
    #2 rst = 1'b1;
    #1;
    chk("async_reset", dut_state(), pack(8'd0, 1'b1, 1'b0, 1'b0, 8'd5));
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_reset_pulse", dut_state(), pack(8'd1, 1'b0, 1'b0, 1'b0, 8'd5));
    step();
    step();
    step();
    step();
    chk("post_reset_wrap", dut_state(), pack(8'd0, 1'b1, 1'b1, 1'b0, 8'd5));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
